// File: rtl/chan_link_pkg.sv
// Shared types and constants for the one-channel link RX frame checker.
package chan_link_pkg;
  typedef enum logic [1:0] {HDR, PAYLOAD, TRAILER, DISCARD} state_t;

  localparam int ERR_MAGIC = 0;
  localparam int ERR_LEN   = 1;
  localparam int ERR_CSUM  = 2;

  localparam logic [15:0] DEF_MAGIC = 16'hA5A5;
endpackage

// File: rtl/chan_rx_frame_checker_if.sv
// Word-granular AXI4-stream bundle; tdata uses [0:31] ordering, bit 0 = MSB.
interface chan_rx_frame_checker_if;
  logic [0:31] tdata;
  logic [3:0]  tkeep;
  logic        tvalid;
  logic        tlast;
  logic        tready;

  modport master (output tdata, tkeep, tvalid, tlast, input tready);
  modport slave  (input tdata, tkeep, tvalid, tlast, output tready);
endinterface

// File: rtl/chan_rx_frame_checker_reg_slice.sv
// Two-entry skid buffer: fully registered output, 1 word/cycle under continuous ready.
module chan_axis_reg_slice #(
  parameter int W = 33
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [W-1:0] in_data,
  input  logic         in_valid,
  output logic         in_ready,
  output logic [W-1:0] out_data,
  output logic         out_valid,
  input  logic         out_ready
);
  logic [W-1:0] skid;
  logic         skid_v;

  // in_ready depends only on registered state, so no comb path from out_ready.
  assign in_ready = !skid_v;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_data  <= '0;
      out_valid <= 1'b0;
      skid      <= '0;
      skid_v    <= 1'b0;
    end else if (out_ready || !out_valid) begin
      if (skid_v) begin
        out_data  <= skid;
        out_valid <= 1'b1;
        skid_v    <= 1'b0;
      end else begin
        out_valid <= in_valid;
        if (in_valid) out_data <= in_data;
      end
    end else if (in_valid && !skid_v) begin
      skid   <= in_data;
      skid_v <= 1'b1;
    end
  end
endmodule

// File: rtl/chan_rx_frame_checker.sv
// RX frame checker: strips header/trailer, forwards payload, checks magic/length/XOR, counts frames.
module chan_rx_frame_checker
  import chan_link_pkg::*;
#(
  parameter logic [15:0] MAGIC   = DEF_MAGIC,
  parameter int          MAX_LEN = 1024,
  parameter int          CNT_W   = 32
) (
  input  logic                     m_axis_aclk,
  input  logic                     m_axis_aresetn,
  chan_rx_frame_checker_if.slave   s_axis_rx,
  chan_rx_frame_checker_if.master  m_axis_pl,
  output logic                     frame_done,
  output logic                     frame_ok,
  output logic [2:0]               err_code,
  output logic [CNT_W-1:0]         good_cnt,
  output logic [CNT_W-1:0]         bad_cnt,
  input  logic                     clr_cnt
);
  state_t      state, nxt;
  logic        live;
  logic [31:0] word, csum;
  logic [15:0] rem;
  logic [2:0]  err_acc, err_set, err_all;
  logic        acc, fin, hdr_bad;
  logic        fwd_valid, fwd_last, slice_ready;
  logic [32:0] slice_out;
  logic        unused_keep;

  assign unused_keep = ^s_axis_rx.tkeep;
  assign word    = s_axis_rx.tdata;
  assign acc     = s_axis_rx.tvalid && s_axis_rx.tready;
  assign hdr_bad = (word[31:16] != MAGIC) || (word[15:0] > 16'(MAX_LEN));
  assign err_all = err_acc | err_set;

  always_ff @(posedge m_axis_aclk or negedge m_axis_aresetn) begin
    if (!m_axis_aresetn) begin
      state <= HDR;
      live  <= 1'b0;
    end else begin
      state <= nxt;
      live  <= 1'b1;
    end
  end

  always_comb begin
    nxt     = state;
    fin     = 1'b0;
    err_set = '0;
    if (acc) begin
      unique case (state)
        HDR: begin
          if (hdr_bad) begin
            err_set[ERR_MAGIC] = 1'b1;
            if (s_axis_rx.tlast) fin = 1'b1;
            else nxt = DISCARD;
          end else if (s_axis_rx.tlast) begin
            err_set[ERR_LEN] = 1'b1;
            fin = 1'b1;
          end else if (word[15:0] == 16'd0) nxt = TRAILER;
          else nxt = PAYLOAD;
        end
        // Any tlast inside the payload is an error: early end or missing trailer.
        PAYLOAD: begin
          if (s_axis_rx.tlast) begin
            err_set[ERR_LEN] = 1'b1;
            fin = 1'b1;
          end else if (rem == 16'd1) nxt = TRAILER;
        end
        TRAILER: begin
          if (!s_axis_rx.tlast) begin
            err_set[ERR_LEN] = 1'b1;
            nxt = DISCARD;
          end else begin
            fin = 1'b1;
            if (word != csum) err_set[ERR_CSUM] = 1'b1;
          end
        end
        DISCARD: if (s_axis_rx.tlast) fin = 1'b1;
        default: nxt = HDR;
      endcase
    end
    if (fin) nxt = HDR;
  end

  always_comb begin
    s_axis_rx.tready = live && ((state == PAYLOAD) ? slice_ready : 1'b1);
    fwd_valid        = (state == PAYLOAD) && s_axis_rx.tvalid;
    fwd_last         = (rem == 16'd1) || s_axis_rx.tlast;
  end

  always_ff @(posedge m_axis_aclk or negedge m_axis_aresetn) begin
    if (!m_axis_aresetn) begin
      csum       <= '0;
      rem        <= '0;
      err_acc    <= '0;
      frame_done <= 1'b0;
      frame_ok   <= 1'b0;
      err_code   <= '0;
      good_cnt   <= '0;
      bad_cnt    <= '0;
    end else begin
      if (acc && state == HDR) begin
        csum <= word;
        rem  <= word[15:0];
      end else if (acc && state == PAYLOAD) begin
        csum <= csum ^ word;
        rem  <= rem - 16'd1;
      end
      err_acc    <= fin ? 3'b000 : err_all;
      frame_done <= fin;
      if (fin) begin
        err_code <= err_all;
        frame_ok <= (err_all == 3'b000);
      end
      // Clear takes priority over a same-cycle increment.
      if (clr_cnt) begin
        good_cnt <= '0;
        bad_cnt  <= '0;
      end else if (fin) begin
        if (err_all == 3'b000) begin
          if (good_cnt != '1) good_cnt <= good_cnt + CNT_W'(1);
        end else if (bad_cnt != '1) bad_cnt <= bad_cnt + CNT_W'(1);
      end
    end
  end

  chan_axis_reg_slice #(.W(33)) u_slice (
    .clk       (m_axis_aclk),
    .rst_n     (m_axis_aresetn),
    .in_data   ({fwd_last, word}),
    .in_valid  (fwd_valid),
    .in_ready  (slice_ready),
    .out_data  (slice_out),
    .out_valid (m_axis_pl.tvalid),
    .out_ready (m_axis_pl.tready)
  );

  assign m_axis_pl.tdata = slice_out[31:0];
  assign m_axis_pl.tlast = slice_out[32];
  assign m_axis_pl.tkeep = {4{m_axis_pl.tvalid}};
endmodule
